speed_mode_sequencer: RTL and testbench

//  Runs on clk_100mhz; owns the speed-select path feeding the clock mux and its gated counter.
//  - Synchronises and debounces the two mode switches.
//  - Waits for the clock generator's locked status before it enables any clock.
//  - Changes mode with a gate-off / switch / settle sequence, so the mux select never moves while the clock enable is high.

---
 rtl/speed_mode_sequencer_pkg.sv | 27 ++
 rtl/speed_mode_sequencer_sw_debounce.sv | 37 +++
 rtl/speed_mode_sequencer.sv | 142 ++++++++++++++
 tb/tb_speed_mode_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_mode_sequencer_pkg.sv
// Shared definitions for the speed-select path: mode codes, FSM state
// encodings and default timing parameters.
package speed_mode_sequencer_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_MED  = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_SWITCH    = 3'd3,
    ST_SETTLE    = 3'd4
  } state_t;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_GUARD_CYCLES    = 16;

  // Mode 00 parks the downstream counter, every other mode runs it.
  function automatic logic mode_enables_clock(input logic [1:0] mode);
    return (mode != MODE_STOP);
  endfunction

endpackage

// File: rtl/speed_mode_sequencer_sw_debounce.sv
// Debouncer for an already-synchronised multi-bit level. The output only
// follows the input once it has held one value for DEBOUNCE_CYCLES cycles.
module sw_debounce
  import speed_mode_sequencer_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] level_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] hold_cnt;

  // Down-counter restarts on every change; terminal count commits the candidate.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      candidate <= '0;
      hold_cnt  <= '0;
      level_db  <= '0;
    end else if (level != candidate) begin
      candidate <= level;
      hold_cnt  <= RELOAD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else begin
      level_db <= candidate;
    end
  end

endmodule

// File: rtl/speed_mode_sequencer.sv
// Speed-select sequencer for the clock mux and its gated counter.
// Conditions the mode switches and lock status, then moves the mux select
// only while the clock enable is held low for a guard period on each side.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_LOCK  | clocking wizard not locked, clk_en low, clk_sel held
// RUN        | clock enabled for non-stop modes, watching for a mode change
// DRAIN      | clk_en low for GUARD_CYCLES before the select moves
// SWITCH     | one cycle: clk_sel takes the latched target, count bumps
// SETTLE     | clk_en low for GUARD_CYCLES after the select moved
module speed_mode_sequencer
  import speed_mode_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int GUARD_CYCLES    = DEFAULT_GUARD_CYCLES
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       locked,
  output logic [1:0] clk_sel,
  output logic       clk_en,
  output logic       busy,
  output logic       mode_changed,
  output logic [7:0] switch_count
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  // Bit 2 carries locked, bits 1:0 carry sw; all share one synchroniser chain.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [1:0]                  sw_s;
  logic                        locked_s;
  logic [1:0]                  sw_db;

  state_t             state;
  logic [1:0]         target;
  logic [GUARD_W-1:0] guard_cnt;

  assign sw_s     = sync_q[SYNC_STAGES-1][1:0];
  assign locked_s = sync_q[SYNC_STAGES-1][2];

  // Shift the asynchronous inputs through SYNC_STAGES flops.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {locked, sw}};
    end
  end

  sw_debounce #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .level      (sw_s),
    .level_db   (sw_db)
  );

  // Sequencing FSM with registered outputs; loss of lock overrides everything.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state        <= ST_WAIT_LOCK;
      clk_sel      <= MODE_STOP;
      clk_en       <= 1'b0;
      busy         <= 1'b1;
      mode_changed <= 1'b0;
      switch_count <= 8'd0;
      guard_cnt    <= '0;
      target       <= MODE_STOP;
    end else begin
      mode_changed <= 1'b0;
      if ((state != ST_WAIT_LOCK) && !locked_s) begin
        state  <= ST_WAIT_LOCK;
        clk_en <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            clk_en <= 1'b0;
            busy   <= 1'b1;
            if (locked_s) begin
              target    <= sw_db;
              guard_cnt <= '0;
              state     <= ST_SWITCH;
            end
          end
          ST_RUN: begin
            if (sw_db != clk_sel) begin
              target    <= sw_db;
              clk_en    <= 1'b0;
              busy      <= 1'b1;
              guard_cnt <= '0;
              state     <= ST_DRAIN;
            end else begin
              clk_en <= mode_enables_clock(clk_sel);
              busy   <= 1'b0;
            end
          end
          ST_DRAIN: begin
            clk_en <= 1'b0;
            if (guard_cnt == GUARD_LAST) begin
              guard_cnt <= '0;
              state     <= ST_SWITCH;
            end else begin
              guard_cnt <= guard_cnt + 1'b1;
            end
          end
          ST_SWITCH: begin
            clk_en       <= 1'b0;
            clk_sel      <= target;
            switch_count <= switch_count + 8'd1;
            mode_changed <= (target != clk_sel);
            guard_cnt    <= '0;
            state        <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (guard_cnt == GUARD_LAST) begin
              clk_en <= mode_enables_clock(clk_sel);
              busy   <= 1'b0;
              state  <= ST_RUN;
            end else begin
              clk_en    <= 1'b0;
              guard_cnt <= guard_cnt + 1'b1;
            end
          end
          default: begin
            clk_en <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_WAIT_LOCK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_speed_mode_sequencer.sv
// Scoreboard bench for speed_mode_sequencer with short debounce and guard times.
module tb_speed_mode_sequencer;

  localparam int KIND_MC  = 0;  // mode_changed pulse observed
  localparam int KIND_RUN = 1;  // busy fell (entered RUN)

  typedef struct {
    int         kind;
    logic [1:0] sel;
    logic       en;
    logic [7:0] cnt;
    int         low;   // prior consecutive clk_en-low cycles, -1 = ignore
  } ev_t;

  logic       clk_100mhz = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic       locked;
  logic [1:0] clk_sel;
  logic       clk_en;
  logic       busy;
  logic       mode_changed;
  logic [7:0] switch_count;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  speed_mode_sequencer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .GUARD_CYCLES    (4)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .sw           (sw),
    .locked       (locked),
    .clk_sel      (clk_sel),
    .clk_en       (clk_en),
    .busy         (busy),
    .mode_changed (mode_changed),
    .switch_count (switch_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] sel, input logic en,
                      input logic [7:0] cnt, input int low);
    ev_t e;
    e.kind = kind; e.sel = sel; e.en = en; e.cnt = cnt; e.low = low;
    exp_q.push_back(e);
  endtask

  task automatic score(input ev_t o);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind=%0d sel=%0d en=%0d cnt=%0d low=%0d, expected no event (t=%0t)",
               o.kind, o.sel, o.en, o.cnt, o.low, $time);
    end else begin
      e = exp_q.pop_front();
      if (o.kind != e.kind || o.sel != e.sel || o.en != e.en || o.cnt != e.cnt ||
          (e.low >= 0 && o.low != e.low)) begin
        fails++;
        $display("FAIL event: got kind=%0d sel=%0d en=%0d cnt=%0d low=%0d, expected kind=%0d sel=%0d en=%0d cnt=%0d low=%0d (t=%0t)",
                 o.kind, o.sel, o.en, o.cnt, o.low, e.kind, e.sel, e.en, e.cnt, e.low, $time);
      end
    end
  endtask

  // Monitor: samples on the falling edge and scores every output event.
  initial begin
    logic prev_busy;
    int   low_run;
    ev_t  o;
    prev_busy = 1'b1;
    low_run   = 0;
    forever begin
      @(negedge clk_100mhz);
      if (!rst) begin
        if (mode_changed) begin
          o.kind = KIND_MC; o.sel = clk_sel; o.en = clk_en; o.cnt = switch_count; o.low = low_run;
          score(o);
        end
        if (prev_busy && !busy) begin
          o.kind = KIND_RUN; o.sel = clk_sel; o.en = clk_en; o.cnt = switch_count; o.low = low_run;
          score(o);
        end
      end
      prev_busy = busy;
      low_run   = clk_en ? 0 : low_run + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int n = 0;
    while (busy !== val && n < max) begin
      @(negedge clk_100mhz);
      n++;
    end
    if (busy !== val) begin
      checks++; fails++;
      $display("FAIL %s: timeout, busy=%0d, expected %0d", name, busy, val);
    end
  endtask

  task automatic wait_q_empty(input int max, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk_100mhz);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL %s: timeout, %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Directed stimulus.
  initial begin
    int n;
    int lows;
    rst = 1'b1; sw = 2'b01; locked = 1'b0;
    tick(3);
    check("reset_clk_sel", clk_sel, 0);
    check("reset_clk_en", clk_en, 0);
    check("reset_busy", busy, 1);
    check("reset_mode_changed", mode_changed, 0);
    check("reset_switch_count", switch_count, 0);
    rst = 1'b0;
    tick(20);
    check("unlocked_clk_en", clk_en, 0);
    check("unlocked_busy", busy, 1);

    // 1: first lock brings up mode 01 after sync + SWITCH + SETTLE.
    push(KIND_MC, 2'b01, 1'b0, 8'd1, -1);
    push(KIND_RUN, 2'b01, 1'b1, 8'd1, -1);
    locked = 1'b1;
    n = 0;
    while (clk_en !== 1'b1 && n < 50) begin
      @(negedge clk_100mhz);
      n++;
    end
    check("lock_to_clk_en_edges", n, 8);
    wait_q_empty(10, "lock_events");
    check("lock_switch_count", switch_count, 1);

    // 2: short glitch must not reach the debounced mode.
    sw = 2'b11;
    tick(3);
    sw = 2'b01;
    lows = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_100mhz);
      if (!clk_en) lows++;
    end
    check("glitch_clk_en_low_cycles", lows, 0);
    check("glitch_clk_sel", clk_sel, 1);
    check("glitch_switch_count", switch_count, 1);

    // 3: held change 01 -> 11, 9 low cycles, select moves on the 6th.
    push(KIND_MC, 2'b11, 1'b0, 8'd2, 5);
    push(KIND_RUN, 2'b11, 1'b1, 8'd2, 9);
    sw = 2'b11;
    wait_q_empty(100, "switch_to_11");

    // 4: stop mode keeps clk_en low while in RUN.
    push(KIND_MC, 2'b00, 1'b0, 8'd3, 5);
    push(KIND_RUN, 2'b00, 1'b0, 8'd3, 9);
    sw = 2'b00;
    wait_q_empty(100, "switch_to_00");
    tick(5);
    check("stop_busy", busy, 0);
    check("stop_clk_en", clk_en, 0);
    check("stop_clk_sel", clk_sel, 0);

    // 5: lock lost during DRAIN, sequence resumes on re-lock.
    push(KIND_MC, 2'b10, 1'b0, 8'd4, -1);
    push(KIND_RUN, 2'b10, 1'b1, 8'd4, -1);
    sw = 2'b10;
    wait_busy(1'b1, 100, "enter_drain");
    locked = 1'b0;
    tick(8);
    check("unlock_clk_sel", clk_sel, 0);
    check("unlock_clk_en", clk_en, 0);
    check("unlock_busy", busy, 1);
    check("unlock_switch_count", switch_count, 3);
    tick(20);
    check("unlock_hold_switch_count", switch_count, 3);
    check("unlock_pending_events", exp_q.size(), 2);
    locked = 1'b1;
    wait_q_empty(100, "relock_to_10");

    // 6: asynchronous reset in SETTLE, observed before any clock edge.
    push(KIND_MC, 2'b01, 1'b0, 8'd5, 5);
    sw = 2'b01;
    n = 0;
    while (mode_changed !== 1'b1 && n < 100) begin
      @(negedge clk_100mhz);
      n++;
    end
    check("settle_mode_changed_seen", mode_changed, 1);
    tick(1);
    rst = 1'b1;
    #1;
    check("async_rst_clk_sel", clk_sel, 0);
    check("async_rst_clk_en", clk_en, 0);
    check("async_rst_busy", busy, 1);
    check("async_rst_switch_count", switch_count, 0);
    exp_q.delete();
    sw = 2'b00; locked = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);

    // 256 lock acquisitions in stop mode wrap the switch counter.
    for (int k = 1; k <= 256; k++) begin
      push(KIND_RUN, 2'b00, 1'b0, 8'(k), -1);
      locked = 1'b1;
      wait_busy(1'b0, 50, "wrap_enter_run");
      locked = 1'b0;
      wait_busy(1'b1, 50, "wrap_leave_run");
    end
    wait_q_empty(20, "wrap_events");
    check("wrap_switch_count", switch_count, 0);
    check("wrap_clk_sel", clk_sel, 0);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
